// File: rtl/ecg_io_shell.sv
// rtl/ecg_io_shell.sv - word-serial operand/result shell around the point scalar multiplier
// Optional run watchdog enabled by defining ECG_IO_TIMEOUT_EN.
`ifndef WIDTH
`define WIDTH 162
`endif
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 162
`endif

module ecg_io_shell #(
  parameter int BUS_W          = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUS_W-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUS_W-1:0]         out_data,
  output logic                     busy,
  output logic                     psm_reset,
  output logic [`WIDTH:0]          psm_x1,
  output logic [`WIDTH:0]          psm_y1,
  output logic                     psm_zero1,
  output logic [`SCALAR_WIDTH:0]   psm_c,
  input  logic                     psm_done,
  input  logic [`WIDTH:0]          psm_x3,
  input  logic [`WIDTH:0]          psm_y3,
  input  logic                     psm_zero3
);
  localparam int FW   = `WIDTH + 1;
  localparam int SW   = `SCALAR_WIDTH + 1;
  localparam int NF   = (FW + BUS_W - 1) / BUS_W;
  localparam int NS   = (SW + BUS_W - 1) / BUS_W;
  localparam int NMAX = (NF > NS) ? NF : NS;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int PW   = NF * BUS_W;
  localparam int SHW  = 2 * PW;

  // Bit 2 clear marks the load states.
  localparam logic [2:0] LOAD_X = 3'd0, LOAD_Y = 3'd1, LOAD_Z = 3'd2, LOAD_C = 3'd3;
  localparam logic [2:0] RUN    = 3'd4, OUT_X  = 3'd5, OUT_Y  = 3'd6, OUT_Z  = 3'd7;

  logic [2:0]                 state;
  logic [CW-1:0]              cnt;
  logic                       ready_en;
  logic                       run_first;
  logic [SHW-1:0]             out_sh;
  logic                       in_xfer, out_xfer, last_f, last_s;
  logic                       done_hit, timeout_hit;
  logic [FW-1:0]              cap_x, cap_y;
  logic                       cap_z;
  logic [(2*NF+1)*BUS_W-1:0]  frame;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign last_f    = (cnt == CW'(NF - 1));
  assign last_s    = (cnt == CW'(NS - 1));
  assign in_ready  = ready_en & ~state[2];
  assign out_valid = (state == OUT_X) | (state == OUT_Y) | (state == OUT_Z);
  assign busy      = ~((state == LOAD_X) && (cnt == '0));
  assign done_hit  = (state == RUN) & ~run_first & psm_done;

`ifdef ECG_IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cycles;

  always_ff @(posedge clk) begin
    if (reset || state != RUN) run_cycles <= '0;
    else                       run_cycles <= run_cycles + 1'b1;
  end

  assign timeout_hit = (state == RUN) & ~done_hit & (run_cycles == TW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
`endif

  // A watchdog expiry reports the point at infinity with the timeout flag set.
  assign cap_x = timeout_hit ? '0   : psm_x3;
  assign cap_y = timeout_hit ? '0   : psm_y3;
  assign cap_z = timeout_hit ? 1'b1 : psm_zero3;
  assign frame = {BUS_W'({timeout_hit, cap_z}), PW'(cap_y), PW'(cap_x)};

  always_ff @(posedge clk) begin
    if (reset) begin
      psm_x1    <= '0;
      psm_y1    <= '0;
      psm_zero1 <= 1'b1;
      psm_c     <= '0;
    end else if (in_xfer) begin
      case (state)
        LOAD_X: for (int b = 0; b < FW; b++) if (cnt == CW'(b / BUS_W)) psm_x1[b] <= in_data[b % BUS_W];
        LOAD_Y: for (int b = 0; b < FW; b++) if (cnt == CW'(b / BUS_W)) psm_y1[b] <= in_data[b % BUS_W];
        LOAD_Z: psm_zero1 <= in_data[0];
        LOAD_C: for (int b = 0; b < SW; b++) if (cnt == CW'(b / BUS_W)) psm_c[b]  <= in_data[b % BUS_W];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_X;
      cnt       <= '0;
      ready_en  <= 1'b0;
      run_first <= 1'b0;
      psm_reset <= 1'b1;
      out_data  <= '0;
      out_sh    <= '0;
    end else begin
      ready_en  <= 1'b1;
      run_first <= 1'b0;
      case (state)
        LOAD_X, LOAD_Y: if (in_xfer) begin
          if (last_f) begin
            state <= (state == LOAD_X) ? LOAD_Y : LOAD_Z;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        LOAD_Z: if (in_xfer) state <= LOAD_C;
        LOAD_C: if (in_xfer) begin
          if (last_s) begin
            state     <= RUN;
            cnt       <= '0;
            psm_reset <= 1'b0;
            run_first <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        RUN: if (done_hit || timeout_hit) begin
          state     <= OUT_X;
          psm_reset <= 1'b1;
          out_data  <= frame[BUS_W-1:0];
          out_sh    <= frame[(2*NF+1)*BUS_W-1:BUS_W];
        end
        OUT_X, OUT_Y, OUT_Z: if (out_xfer) begin
          out_data <= out_sh[BUS_W-1:0];
          out_sh   <= out_sh >> BUS_W;
          if (state == OUT_Z) begin
            state <= LOAD_X;
            cnt   <= '0;
          end else if (last_f) begin
            state <= (state == OUT_X) ? OUT_Y : OUT_Z;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= LOAD_X;
      endcase
    end
  end
endmodule

// File: tb/tb_ecg_io_shell.sv
// tb/tb_ecg_io_shell.sv - scoreboard bench for ecg_io_shell with a behavioural multiplier stub
`ifndef WIDTH
`define WIDTH 162
`endif
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 162
`endif

module tb_ecg_io_shell;
  localparam int BUS_W = 32;
  localparam int FW    = `WIDTH + 1;
  localparam int SW    = `SCALAR_WIDTH + 1;
  localparam int NF    = (FW + BUS_W - 1) / BUS_W;
  localparam int NS    = (SW + BUS_W - 1) / BUS_W;
  localparam int NMAX  = (NF > NS) ? NF : NS;
  localparam int PW    = NMAX * BUS_W;
  localparam int TO    = 16;
  localparam int DLY   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [BUS_W-1:0] in_data = '0;
  logic             in_ready, out_valid, busy, psm_reset, psm_zero1;
  logic [BUS_W-1:0] out_data;
  logic [FW-1:0]    psm_x1, psm_y1;
  logic [SW-1:0]    psm_c;
  logic             psm_done = 1'b0;
  logic [FW-1:0]    psm_x3 = '0, psm_y3 = '0;
  logic             psm_zero3 = 1'b0;
  logic             stub_en = 1'b1;
  int               stub_cnt = 0;

  logic [BUS_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ecg_io_shell #(.BUS_W(BUS_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .psm_reset(psm_reset),
    .psm_x1(psm_x1), .psm_y1(psm_y1), .psm_zero1(psm_zero1), .psm_c(psm_c),
    .psm_done(psm_done), .psm_x3(psm_x3), .psm_y3(psm_y3), .psm_zero3(psm_zero3)
  );

  // Stand-in multiplier: c=0 or infinity -> infinity, c=1 -> P, otherwise (x^c, ~y).
  function automatic logic model_inf(input logic z, input logic [SW-1:0] c);
    return z || (c == '0);
  endfunction
  function automatic logic [FW-1:0] model_x(input logic [FW-1:0] x, input logic z, input logic [SW-1:0] c);
    if (model_inf(z, c)) return '0;
    return (c == SW'(1)) ? x : (x ^ FW'(c));
  endfunction
  function automatic logic [FW-1:0] model_y(input logic [FW-1:0] y, input logic z, input logic [SW-1:0] c);
    if (model_inf(z, c)) return '0;
    return (c == SW'(1)) ? y : ~y;
  endfunction

  always @(posedge clk) begin
    if (psm_reset) begin
      stub_cnt <= 0;
      psm_done <= 1'b0;
      psm_x3 <= '0;
      psm_y3 <= '0;
      psm_zero3 <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_en && stub_cnt == DLY - 1) begin
        psm_done  <= 1'b1;
        psm_x3    <= model_x(psm_x1, psm_zero1, psm_c);
        psm_y3    <= model_y(psm_y1, psm_zero1, psm_c);
        psm_zero3 <= model_inf(psm_zero1, psm_c);
      end
    end
  end

  function automatic logic [FW-1:0] rand_field();
    logic [FW-1:0] v = '0;
    for (int i = 0; i < FW; i += 32) v = (v << 32) | FW'($urandom);
    return v;
  endfunction

  task automatic send_word(input logic [BUS_W-1:0] w);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL in_ready_wait got %b want 1", in_ready);
      bad++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Last word carries random junk above the field's top bit; the shell must drop it.
  task automatic send_field(input logic [PW-1:0] v, input int nwords, input int nbits);
    logic [BUS_W-1:0] w, lm;
    for (int i = 0; i < nwords; i++) begin
      w = v[i*BUS_W +: BUS_W];
      if (i == nwords - 1) begin
        lm = '1;
        lm = lm >> (BUS_W - (nbits - (nwords - 1) * BUS_W));
        w = (w & lm) | ($urandom & ~lm);
      end
      send_word(w);
    end
  endtask

  task automatic push_field(input logic [FW-1:0] v);
    logic [PW-1:0] p = '0;
    p[FW-1:0] = v;
    for (int i = 0; i < NF; i++) exp_q.push_back(p[i*BUS_W +: BUS_W]);
  endtask

  task automatic load_op(input logic [FW-1:0] x, input logic [FW-1:0] y, input logic z,
                         input logic [SW-1:0] c, input logic timeout);
    total++;
    if (psm_reset !== 1'b1) begin
      $display("FAIL psm_reset_load got %b want 1", psm_reset);
      bad++;
    end
    send_field(PW'(x), NF, FW);
    send_field(PW'(y), NF, FW);
    send_word(BUS_W'(($urandom & ~32'h3) | {31'd0, z}));
    send_field(PW'(c), NS, SW);
    total++;
    if (psm_x1 !== x || psm_y1 !== y || psm_zero1 !== z || psm_c !== c) begin
      $display("FAIL operands got x=%h y=%h z=%b c=%h want x=%h y=%h z=%b c=%h", psm_x1, psm_y1, psm_zero1, psm_c, x, y, z, c);
      bad++;
    end
    if (timeout) begin
      push_field('0);
      push_field('0);
      exp_q.push_back(BUS_W'(3));
    end else begin
      push_field(model_x(x, z, c));
      push_field(model_y(y, z, c));
      exp_q.push_back(BUS_W'(model_inf(z, c)));
    end
  endtask

  // Called right after the final scalar word transfer.
  task automatic run_drain(input int exp_lat, input int hold_at);
    int t = 0;
    int n;
    int guard;
    logic [BUS_W-1:0] held, exp_w;
    total++;
    if (psm_reset !== 1'b0) begin
      $display("FAIL psm_reset_run got %b want 0", psm_reset);
      bad++;
    end
    while (!out_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    total++;
    if (t !== exp_lat) begin
      $display("FAIL run_latency got %0d want %0d", t, exp_lat);
      bad++;
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == hold_at) begin
        out_ready = 1'b0;
        held = out_data;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          total++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            $display("FAIL hold_stable got v=%b d=%h want v=1 d=%h", out_valid, out_data, held);
            bad++;
          end
        end
      end
      out_ready = 1'b1;
      guard = 0;
      while (!out_valid && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      exp_w = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_w) begin
        $display("FAIL out_word[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_w);
        bad++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || psm_reset !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL after_drain got v=%b busy=%b psm_reset=%b in_ready=%b want 0 0 1 1", out_valid, busy, psm_reset, in_ready);
      bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (psm_reset !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      $display("FAIL reset_ctrl got psm_reset=%b in_ready=%b v=%b d=%h busy=%b want 1 0 0 0 0", psm_reset, in_ready, out_valid, out_data, busy);
      bad++;
    end
    total++;
    if (psm_x1 !== '0 || psm_y1 !== '0 || psm_zero1 !== 1'b1 || psm_c !== '0) begin
      $display("FAIL reset_operands got x=%h y=%h z=%b c=%h want 0 0 1 0", psm_x1, psm_y1, psm_zero1, psm_c);
      bad++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL in_ready_rise got %b want 1", in_ready);
      bad++;
    end
  endtask

  task automatic test_zero_point();
    load_op('0, '0, 1'b1, SW'(5), 1'b0);
    run_drain(DLY + 1, -1);
  endtask

  task automatic test_identity();
    load_op(rand_field(), rand_field(), 1'b0, SW'(1), 1'b0);
    run_drain(DLY + 1, -1);
  endtask

  task automatic test_scalar_zero();
    load_op(rand_field(), rand_field(), 1'b0, '0, 1'b0);
    run_drain(DLY + 1, -1);
  endtask

  task automatic test_general();
    load_op(rand_field(), rand_field(), 1'b0, SW'(5), 1'b0);
    run_drain(DLY + 1, -1);
  endtask

  task automatic test_backpressure();
    load_op(rand_field(), rand_field(), 1'b0, SW'(1), 1'b0);
    run_drain(DLY + 1, 1);
  endtask

  task automatic test_reset_midload();
    send_field(PW'(rand_field()), NF, FW);
    for (int i = 0; i < 3; i++) send_word($urandom);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (psm_reset !== 1'b1 || in_ready !== 1'b0 || psm_x1 !== '0) begin
        $display("FAIL midload_reset got psm_reset=%b in_ready=%b x=%h want 1 0 0", psm_reset, in_ready, psm_x1);
        bad++;
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    load_op(rand_field(), rand_field(), 1'b0, SW'(1), 1'b0);
    run_drain(DLY + 1, -1);
  endtask

`ifdef ECG_IO_TIMEOUT_EN
  task automatic test_timeout();
    stub_en = 1'b0;
    load_op(rand_field(), rand_field(), 1'b0, SW'(5), 1'b1);
    run_drain(TO + 1, -1);
    stub_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_point();
    test_identity();
    test_scalar_zero();
    test_general();
    test_backpressure();
    test_reset_midload();
`ifdef ECG_IO_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
